// File: rtl/pixel_hblur_stage.sv
// pixel_hblur_stage
//   Streaming stage between two byte FIFOs. Pops grayscale pixels from the
//   upstream FWFT FIFO, applies a horizontal [1 2 1]/4 smoothing filter with
//   edge replication at both ends of each row, and pushes results downstream.
//   Bypass mode forwards pixels unchanged with identical timing. Row/column
//   position is tracked and end of frame is flagged with a one-cycle pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   mode       0 = bypass, 1 = blur; captured on the first pop of a frame
//   in_empty   upstream FIFO empty flag
//   in_data    upstream FIFO head word (valid while in_empty = 0)
//   in_rd      pop upstream FIFO this cycle
//   out_full   downstream FIFO full flag
//   out_data   word to write downstream
//   out_wr     push downstream FIFO this cycle
//   frame_done one-cycle pulse after the last pixel of a frame is written
//   busy       high from the first pop of a frame until the frame completes
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | waiting to pop the first pixel of a row (no output yet)
// RUN   | pop pixel k+1 and push output k in the same cycle
// FLUSH | push the last output of the row using the replicated right edge
module pixel_hblur_stage #(
  parameter int B     = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int CB    = 8,
  parameter int RB    = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic         in_empty,
  input  logic [B-1:0] in_data,
  output logic         in_rd,
  input  logic         out_full,
  output logic [B-1:0] out_data,
  output logic         out_wr,
  output logic         frame_done,
  output logic         busy
);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  localparam logic [CB-1:0] COL_LAST = CB'(IMG_W - 1);
  localparam logic [RB-1:0] ROW_LAST = RB'(IMG_H - 1);

  state_t        state;
  logic [B-1:0]  prev;
  logic [B-1:0]  cur;
  logic [CB-1:0] col;
  logic [RB-1:0] row;
  logic          mode_q;

  logic          fire;
  logic [B-1:0]  tap_c;
  logic [B+1:0]  sum;

  assign fire = ~in_empty & ~out_full;

  // Right tap is the incoming pixel while streaming; in FLUSH the row has
  // ended, so the right edge is replicated from cur.
  assign tap_c = (state == RUN) ? in_data : cur;

  // a + 2b + c + 2 fits in B+2 bits, so the >>2 result always fits in B.
  assign sum = {2'b00, prev} + {1'b0, cur, 1'b0} + {2'b00, tap_c} + (B+2)'(2);

  assign out_data = mode_q ? B'(sum >> 2) : cur;

  always_comb begin
    in_rd  = 1'b0;
    out_wr = 1'b0;
    if (!reset) begin
      case (state)
        FILL:  in_rd = ~in_empty;
        RUN: begin
          in_rd  = fire;
          out_wr = fire;
        end
        FLUSH: out_wr = ~out_full;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      prev       <= '0;
      cur        <= '0;
      col        <= '0;
      row        <= '0;
      mode_q     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (!in_empty) begin
            // Left edge replication: both history taps start at p0.
            prev  <= in_data;
            cur   <= in_data;
            col   <= CB'(1);
            state <= RUN;
            if (row == '0) begin
              mode_q <= mode;
              busy   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            prev <= cur;
            cur  <= in_data;
            if (col == COL_LAST) begin
              col   <= '0;
              state <= FLUSH;
            end else begin
              col <= col + CB'(1);
            end
          end
        end
        FLUSH: begin
          if (!out_full) begin
            state <= FILL;
            if (row == ROW_LAST) begin
              row        <= '0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              row <= row + RB'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/pixel_hblur_stage.md
Name: pixel_hblur_stage

Overview:
Streaming image-processing stage between two byte FIFOs of the image processor. It pops 8-bit grayscale pixels from the upstream FIFO, applies a horizontal 3-tap [1 2 1]/4 smoothing filter with edge replication per row, and pushes the results into the downstream FIFO. Both sides honour FIFO backpressure. The stage tracks row and column position and flags end of frame. A bypass mode passes pixels through unchanged with identical timing.

Parameters:
B, 8, pixel width in bits
IMG_W, 160, pixels per row (>=2)
IMG_H, 120, rows per frame (>=1)
CB, 8, column counter width (2**CB >= IMG_W)
RB, 7, row counter width (2**RB >= IMG_H)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
mode  input  1  0 = bypass, 1 = blur; sampled at frame start only
in_empty  input  1  upstream FIFO empty flag
in_data  input  B  upstream FIFO head word (first-word-fall-through, valid when in_empty=0)
in_rd  output  1  pop upstream FIFO this cycle
out_full  input  1  downstream FIFO full flag
out_data  output  B  word to write downstream
out_wr  output  1  push downstream FIFO this cycle
frame_done  output  1  one-cycle pulse after last pixel of frame is written
busy  output  1  high while a frame is in progress (any pixel popped and frame not done)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: FSM=FILL, col=0, row=0, prev=0, cur=0, mode_q=0, frame_done=0, busy=0. in_rd and out_wr are 0 while reset is high.
- Registers: prev, cur (B bits), col (CB), row (RB), mode_q, state in {FILL, RUN, FLUSH}.
- in_rd, out_wr and out_data are combinational from state, registers, in_data and flags. Pop and push take effect on the same rising edge.
- FILL (first pixel of a row): in_rd=~in_empty, out_wr=0. On pop: cur<=in_data, prev<=in_data, col<=1, ->RUN. If row==0, mode_q<=mode and busy<=1.
- RUN: fire = ~in_empty & ~out_full. in_rd=out_wr=fire.
  - out_data = f(prev, cur, in_data). On fire: prev<=cur, cur<=in_data, col<=col+1.
  - If the popped pixel is the last of the row (col==IMG_W-1): col<=0, ->FLUSH.
  - Never pop without push, and never push without pop.
- FLUSH (last output of a row): no pop; out_wr=~out_full; out_data=f(prev, cur, cur).
  - On push: ->FILL.
  - If row==IMG_H-1: row<=0, frame_done<=1 next cycle, busy<=0. Otherwise row<=row+1.
- Filter f(a,b,c):
  - blur: (a + 2b + c + 2) >> 2, computed in B+2 bits, truncated to B. Never exceeds 2**B-1, so no saturation logic.
  - bypass: b.
- Edge replication: the left edge uses prev=cur=p0; the right edge uses c=cur.
- Latency: output column k is written in the same cycle pixel k+1 is popped. The last column is written in the FLUSH cycle.
- Throughput: IMG_W+1 cycles per row when unstalled. No pixels are lost or duplicated under any stall pattern.
- Stalls:
  - in_empty or out_full in RUN holds all state.
  - out_full in FLUSH holds state.
  - in_empty in FILL holds state.
- Row and frame boundaries:
  - A mode change mid-frame is ignored until the next row 0 FILL pop.
  - Frames run back to back; the FILL of the next frame may pop in the cycle after the frame_done pulse is set.
- Reset mid-frame aborts immediately: counters cleared, partial row discarded, no further writes.

Test Plan:
- IMG_W=4, IMG_H=1, mode=1, input 10,20,30,40, no stalls -> out 13,20,30,38. frame_done pulses once, 1 cycle after the 4th write. in_rd count=4, out_wr count=4.
- Same params, mode=0, input 7,200,0,255 -> out 7,200,0,255, with the same cycle timing as blur mode.
- mode=1, input all 255 for one row -> all outputs 255 (no overflow). All 0 -> all 0.
- Random out_full (50%) and in_empty (50%) over IMG_W=4, IMG_H=3 frames -> output matches the reference model exactly. in_rd only when ~in_empty, out_wr only when ~out_full. frame_done once per 12 outputs.
- Toggle mode after 2nd pixel of row 0 -> the whole frame uses the old mode. The next frame uses the new mode.
- Assert reset during RUN of row 1 -> in_rd=out_wr=0 immediately. After release, a new frame starting with 10,20,30,40 yields 13,20,30,38.
